// File: rtl/word_byte_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_byte_serializer : buffers 32-bit words (1-4 valid bytes) and streams them
//                        out one byte per cycle over a valid/ready handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
module word_byte_serializer #(
   parameter int FIFO_DEPTH = 2,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [31:0]                   in_data,
   input  logic [2:0]                    in_len,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_byte,
   output logic                          out_last,
   output logic                          len_err,
   output logic [$clog2(FIFO_DEPTH):0]   words_pending
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [2:0]    fifo_len  [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [0:0]    state;
   logic [31:0]   shreg;
   logic [2:0]    remaining;

   logic          accept;
   logic          len_ok;
   logic          push;
   logic          pop;
   logic          out_fire;
   logic [31:0]   head_data;
   logic [2:0]    head_len;

   // Byte ordering lives only in these two helpers.
   function automatic logic [7:0] first_byte(input logic [31:0] w);
      return MSB_FIRST ? w[31:24] : w[7:0];
   endfunction

   function automatic logic [31:0] shift_word(input logic [31:0] w);
      return MSB_FIRST ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
   endfunction

   assign in_ready      = (count != CW'(FIFO_DEPTH));
   assign words_pending = count;
   assign accept        = in_valid && in_ready;
   assign len_ok        = (in_len != 3'd0) && (in_len <= 3'd4);
   assign push          = accept && len_ok;
   assign out_fire      = out_valid && out_ready;
   assign head_data     = fifo_data[rd_ptr];
   assign head_len      = fifo_len[rd_ptr];

   // A word is popped only from registered count, so an empty FIFO never falls through.
   assign pop = (count != '0) && ((state == IDLE) || (out_fire && out_last));

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= in_data;
         fifo_len[wr_ptr]  <= in_len;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         len_err <= 1'b0;
      end else begin
         len_err <= accept && !len_ok;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_byte  <= 8'h00;
         out_last  <= 1'b0;
         shreg     <= '0;
         remaining <= '0;
      end else if (pop) begin
         state     <= SEND;
         out_valid <= 1'b1;
         out_byte  <= first_byte(head_data);
         out_last  <= (head_len == 3'd1);
         shreg     <= shift_word(head_data);
         remaining <= head_len;
      end else if ((state == SEND) && out_fire) begin
         if (out_last) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            out_byte  <= first_byte(shreg);
            shreg     <= shift_word(shreg);
            remaining <= remaining - 3'd1;
            out_last  <= (remaining == 3'd2);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_word_byte_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_word_byte_serializer : directed and randomized bench for word_byte_serializer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_word_byte_serializer;

   logic       clk = 1'b0;
   logic       reset;
   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_len_err;
   logic [31:0] a_in_data;
   logic [2:0]  a_in_len;
   logic [7:0]  a_out_byte;
   logic [1:0]  a_pend;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_len_err;
   logic [31:0] b_in_data;
   logic [2:0]  b_in_len;
   logic [7:0]  b_out_byte;
   logic [1:0]  b_pend;

   word_byte_serializer #(.FIFO_DEPTH(2), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_len(a_in_len),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_byte(a_out_byte),
      .out_last(a_out_last), .len_err(a_len_err), .words_pending(a_pend)
   );

   word_byte_serializer #(.FIFO_DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_len(b_in_len),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_byte(b_out_byte),
      .out_last(b_out_last), .len_err(b_len_err), .words_pending(b_pend)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_b [12];
   logic [7:0] q_byte [$];
   logic       q_last [$];

   initial begin
      int          sent, rx, cyc;
      logic        in_fire, out_fire, ol;
      logic [7:0]  ob;
      logic [31:0] w;
      int          len;

      reset = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_len = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_len = '0; b_out_ready = 1'b0;
      step();
      step();
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_byte", a_out_byte, 8'h00);
      check("rst_out_last", a_out_last, 0);
      check("rst_len_err", a_len_err, 0);
      check("rst_pending", a_pend, 0);
      reset = 1'b0;
      step();
      check("rst_in_ready", a_in_ready, 1);

      // One full word, MSB first
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_in_data = 32'hA1B2C3D4; a_in_len = 3'd4;
      step();
      a_in_valid = 1'b0;
      check("t1_lat_valid", a_out_valid, 0);
      check("t1_lat_pend", a_pend, 1);
      exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
      step();
      check("t1_pend_after_load", a_pend, 0);
      for (int i = 0; i < 4; i++) begin
         check("t1_valid", a_out_valid, 1);
         check("t1_byte", a_out_byte, exp_b[i]);
         check("t1_last", a_out_last, (i == 3) ? 1 : 0);
         step();
      end
      check("t1_idle", a_out_valid, 0);

      // LSB first on the second instance
      b_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_data = 32'hA1B2C3D4; b_in_len = 3'd4;
      step();
      b_in_valid = 1'b0;
      step();
      exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
      for (int i = 0; i < 4; i++) begin
         check("t2_valid", b_out_valid, 1);
         check("t2_byte", b_out_byte, exp_b[i]);
         check("t2_last", b_out_last, (i == 3) ? 1 : 0);
         step();
      end
      check("t2_idle", b_out_valid, 0);
      b_in_valid = 1'b1; b_in_data = 32'h11223344; b_in_len = 3'd2;
      step();
      b_in_valid = 1'b0;
      step();
      check("t2p_byte0", b_out_byte, 8'h44);
      check("t2p_last0", b_out_last, 0);
      step();
      check("t2p_byte1", b_out_byte, 8'h33);
      check("t2p_last1", b_out_last, 1);
      step();
      check("t2p_idle", b_out_valid, 0);

      // Backpressure: three words fill one output register plus two FIFO slots
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'hA1B2C3D4; a_in_len = 3'd4;
      step();
      a_in_data = 32'h01020304;
      step();
      a_in_data = 32'hF0E1D2C3;
      step();
      a_in_data = 32'h99999999;
      for (int i = 0; i < 2; i++) begin
         check("t3_in_ready", a_in_ready, 0);
         check("t3_pend", a_pend, 2);
         check("t3_hold_byte", a_out_byte, 8'hA1);
         check("t3_hold_valid", a_out_valid, 1);
         step();
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2]  = 8'hC3; exp_b[3]  = 8'hD4;
      exp_b[4] = 8'h01; exp_b[5] = 8'h02; exp_b[6]  = 8'h03; exp_b[7]  = 8'h04;
      exp_b[8] = 8'hF0; exp_b[9] = 8'hE1; exp_b[10] = 8'hD2; exp_b[11] = 8'hC3;
      for (int i = 0; i < 12; i++) begin
         check("t3_valid", a_out_valid, 1);
         check("t3_byte", a_out_byte, exp_b[i]);
         check("t3_last", a_out_last, (i % 4 == 3) ? 1 : 0);
         step();
      end
      check("t3_idle", a_out_valid, 0);
      check("t3_pend_end", a_pend, 0);

      // Illegal lengths are accepted, flagged once and dropped
      a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF; a_in_len = 3'd0;
      step();
      a_in_valid = 1'b0;
      check("t4_err0_pulse", a_len_err, 1);
      check("t4_err0_pend", a_pend, 0);
      step();
      check("t4_err0_clear", a_len_err, 0);
      check("t4_err0_novalid", a_out_valid, 0);
      a_in_valid = 1'b1; a_in_len = 3'd5;
      step();
      a_in_valid = 1'b0;
      check("t4_err5_pulse", a_len_err, 1);
      step();
      check("t4_err5_clear", a_len_err, 0);
      step();
      check("t4_novalid", a_out_valid, 0);
      check("t4_pend", a_pend, 0);

      // Asynchronous reset mid-word
      a_in_valid = 1'b1; a_in_data = 32'hA1B2C3D4; a_in_len = 3'd4;
      step();
      a_in_data = 32'h01020304;
      step();
      a_in_valid = 1'b0;
      check("t5_first", a_out_byte, 8'hA1);
      step();
      check("t5_second", a_out_byte, 8'hB2);
      check("t5_pend", a_pend, 1);
      #2 reset = 1'b1;
      #1;
      check("t5_rst_valid", a_out_valid, 0);
      check("t5_rst_pend", a_pend, 0);
      check("t5_rst_byte", a_out_byte, 8'h00);
      @(posedge clk);
      #3 reset = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'h55667788; a_in_len = 3'd3;
      step();
      a_in_valid = 1'b0;
      check("t5_post_lat", a_out_valid, 0);
      step();
      exp_b[0] = 8'h55; exp_b[1] = 8'h66; exp_b[2] = 8'h77;
      for (int i = 0; i < 3; i++) begin
         check("t5_post_byte", a_out_byte, exp_b[i]);
         check("t5_post_last", a_out_last, (i == 2) ? 1 : 0);
         step();
      end
      check("t5_post_idle", a_out_valid, 0);

      // Random valid/ready traffic against a byte-queue model
      sent = 0; rx = 0; cyc = 0;
      while (rx < 300 && cyc < 20000) begin
         if (!a_in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
            a_in_valid = 1'b1;
            a_in_data  = $urandom;
            a_in_len   = 3'($urandom_range(1, 4));
         end
         a_out_ready = ($urandom_range(0, 3) != 0);
         in_fire  = a_in_valid && a_in_ready;
         out_fire = a_out_valid && a_out_ready;
         ob = a_out_byte;
         ol = a_out_last;
         w   = a_in_data;
         len = int'(a_in_len);
         step();
         cyc++;
         if (in_fire) begin
            for (int k = 0; k < len; k++) begin
               q_byte.push_back(w[31 - 8*k -: 8]);
               q_last.push_back(k == len - 1);
            end
            sent++;
            a_in_valid = 1'b0;
         end
         if (out_fire) begin
            if (q_byte.size() == 0) begin
               check("rnd_extra_byte", {24'h0, ob}, 32'hFFFFFFFF);
            end else begin
               check("rnd_byte", ob, q_byte.pop_front());
               check("rnd_last", ol, q_last.pop_front());
               if (ol) rx++;
            end
         end
      end
      check("rnd_words", rx, 300);
      check("rnd_queue_empty", q_byte.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
